fetch_decode: RTL

//  Instruction sequencer directly upstream of the ALU. Fetches 24-bit words from program memory
//  and decodes them into op_code, source selects and operand for the ALU.

---
 rtl/fetch_decode_if.sv | 41 ++++
 rtl/fetch_decode.sv | 101 ++++++++++
 2 files changed

// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - program memory, ALU and word memory bus bundle for fetch_decode
interface fetch_decode_if #(
  parameter int WIDTH    = 8,
  parameter int IWIDTH   = 8,
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] pm_addr;
  logic                pm_rd;
  logic [23:0]         pm_rdata;
  logic                pm_valid;
  logic [IWIDTH-1:0]   op_code;
  logic [1:0]          source1_choice;
  logic [1:0]          source2_choice;
  logic [WIDTH-1:0]    operand;
  logic [WIDTH-1:0]    alu_out;
  logic                alu_c_out;
  logic                alu_b_out;
  logic                alu_c_in;
  logic                alu_b_in;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_addr;
  logic [WIDTH-1:0]    mem_wdata;

  modport master (
    output pm_addr, pm_rd,
    input  pm_rdata, pm_valid,
    output op_code, source1_choice, source2_choice, operand,
    input  alu_out, alu_c_out, alu_b_out,
    output alu_c_in, alu_b_in,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  pm_addr, pm_rd,
    output pm_rdata, pm_valid,
    input  op_code, source1_choice, source2_choice, operand,
    output alu_out, alu_c_out, alu_b_out,
    input  alu_c_in, alu_b_in,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - fetch/decode/execute sequencer feeding the ALU
module fetch_decode #(
  parameter int WIDTH    = 8,
  parameter int IWIDTH   = 8,
  parameter int PC_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  fetch_decode_if.master   bus,
  output logic [WIDTH-1:0] acc,
  output logic             halted
);
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [23:0]         instr;
  logic                cf;
  logic                bf;

  logic [7:0]          opc;
  logic [WIDTH-1:0]    imm;
  logic                acc_wr;
  logic                is_store;
  logic                is_halt;
  logic                jump_taken;
  logic                fetch_done;

  assign opc        = instr[23:16];
  assign imm        = WIDTH'(instr[7:0]);
  assign acc_wr     = (opc <= 8'h11) || (opc == 8'h1B) || (opc == 8'h1C) || (opc == 8'h1F);
  assign is_store   = (opc == 8'h1D) || (opc == 8'h1E);
  assign is_halt    = (opc == 8'h3F);
  assign jump_taken = (opc == 8'h20) || ((opc == 8'h21) && cf);
  assign fetch_done = (state == S_FETCH) && en && bus.pm_valid;

  // ALU-facing fields come straight from the instruction register, so they hold between fetches
  assign bus.op_code        = IWIDTH'(opc);
  assign bus.source1_choice = instr[15:14];
  assign bus.source2_choice = instr[13:12];
  assign bus.operand        = imm;
  assign bus.alu_c_in       = cf;
  assign bus.alu_b_in       = bf;
  assign bus.pm_addr        = pc;
  assign bus.mem_addr       = imm;
  assign bus.mem_wdata      = bus.alu_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state: fetch waits for valid data while enabled, halt is terminal
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (en && bus.pm_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = is_halt ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Control outputs; pm_rd is masked while reset is held so the bus stays quiet
  always_comb begin
    bus.pm_rd  = 1'b0;
    bus.mem_we = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: bus.pm_rd  = en && rst_n;
      S_EXEC:  bus.mem_we = is_store;
      S_HALT:  halted     = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch the fetched word, then commit pc/acc/flags at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      acc   <= '0;
      cf    <= 1'b0;
      bf    <= 1'b0;
      instr <= '0;
    end else begin
      if (fetch_done) instr <= bus.pm_rdata;
      if (state == S_EXEC) begin
        if (acc_wr)           acc <= bus.alu_out;
        if (opc == 8'h07)     cf  <= bus.alu_c_out;
        if (opc == 8'h08)     bf  <= bus.alu_b_out;
        if (is_halt)          pc  <= pc;
        else if (jump_taken)  pc  <= PC_WIDTH'(imm);
        else                  pc  <= pc + PC_WIDTH'(1);
      end
    end
  end
endmodule
